// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the serial-load LUT configuration loader.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int DEF_IN_WIDTH  = 4;
    localparam int DEF_OUT_WIDTH = 3;
    localparam int LUT_DEPTH     = 2 ** DEF_IN_WIDTH;
    localparam int TABLE_BITS    = LUT_DEPTH * DEF_OUT_WIDTH;

    // A one-bit entry still needs a one-bit counter.
    function automatic int bit_cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lut_entry_serializer.sv
// Loads one table entry on a strobe and shifts it out MSB-first on d while cs_n is low;
// last marks the cycle carrying the final bit.
module lut_entry_serializer
    import lut_cfg_pkg::*;
#(
    parameter int WIDTH = DEF_OUT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             d,
    output logic             cs_n,
    output logic             last
);

    localparam int CW = bit_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg <= '0;
            cnt   <= '0;
            d     <= 1'b0;
            cs_n  <= 1'b1;
        end else if (load) begin
            // The MSB goes out immediately; the remainder waits left-justified.
            shreg <= data << 1;
            cnt   <= '0;
            d     <= data[WIDTH-1];
            cs_n  <= 1'b0;
        end else if (!cs_n) begin
            if (cnt == LAST_CNT) begin
                d    <= 1'b0;
                cs_n <= 1'b1;
            end else begin
                d     <= shreg[WIDTH-1];
                shreg <= shreg << 1;
                cnt   <= cnt + 1'b1;
            end
        end
    end

    assign last = !cs_n && (cnt == LAST_CNT);

endmodule

// File: rtl/lut_config_loader.sv
// Sequencer that walks the LUT table from the top index down, handing each entry to the
// serializer and flagging table_valid only after an uninterrupted full load.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [OUT_WIDTH-1:0] entry_data,
    input  logic                 entry_valid,
    output logic                 entry_ready,
    output logic [IN_WIDTH-1:0]  entry_idx,
    output logic                 lut_d,
    output logic                 lut_cs_n,
    output logic                 busy,
    output logic                 done,
    output logic                 table_valid
);

    localparam logic [IN_WIDTH-1:0] IDX_TOP = {IN_WIDTH{1'b1}};

    state_t state;
    state_t state_next;
    logic   accept;
    logic   last_bit;

    assign entry_ready = (state == ST_WAIT);
    assign accept      = entry_ready && entry_valid && !abort;

    lut_entry_serializer #(
        .WIDTH(OUT_WIDTH)
    ) u_serializer (
        .clk  (clk),
        .rst  (rst),
        .clear(abort),
        .load (accept),
        .data (entry_data),
        .d    (lut_d),
        .cs_n (lut_cs_n),
        .last (last_bit)
    );

    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start && !abort) state_next = ST_WAIT;
            ST_WAIT: begin
                if (abort)            state_next = ST_IDLE;
                else if (entry_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort)         state_next = ST_IDLE;
                else if (last_bit) state_next = (entry_idx == '0) ? ST_DONE : ST_WAIT;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            entry_idx   <= IDX_TOP;
            busy        <= 1'b0;
            done        <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            done  <= (state_next == ST_DONE);

            if (state_next == ST_IDLE)
                entry_idx <= IDX_TOP;
            else if (state == ST_SHIFT && state_next == ST_WAIT)
                entry_idx <= entry_idx - 1'b1;

            // A started or interrupted load leaves the LUT untrustworthy until DONE.
            if (state == ST_IDLE && start && !abort)
                table_valid <= 1'b0;
            else if (abort && state != ST_IDLE)
                table_valid <= 1'b0;
            else if (state_next == ST_DONE)
                table_valid <= 1'b1;
        end
    end

endmodule
